uart_tx: RTL and testbench

Memory-mapped UART transmitter peripheral on the bridge's peripheral bus, a sibling of the two timers. It uses the same word-address, single write-enable and combinational read-data convention as the timers. The CPU writes bytes into a 4-entry FIFO, and the block serialises them as 8N1 frames on `txd` at a programmable bit period. It raises a level IRQ when the transmitter has drained, which feeds the CPU's external-interrupt inputs.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_fifo.sv | 71 +++++++
 rtl/uart_tx.sv | 167 ++++++++++++++++
 tb/tb_uart_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Register map, STATUS bit positions and FSM state type for uart_tx.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam logic [1:0] c_REG_CTRL   = 2'd0;
    localparam logic [1:0] c_REG_DIV    = 2'd1;
    localparam logic [1:0] c_REG_DATA   = 2'd2;
    localparam logic [1:0] c_REG_STATUS = 2'd3;

    localparam int c_STAT_BUSY    = 0;
    localparam int c_STAT_EMPTY   = 1;
    localparam int c_STAT_FULL    = 2;
    localparam int c_STAT_OVF     = 3;
    localparam int c_STAT_CNT_LSB = 4;
    localparam int c_STAT_CNT_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo
// Brief    : Synchronous power-of-two FIFO; a push while full is accepted only
//            when a pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_pop_ok;
    logic               w_push_ok;

    assign o_full    = (r_count == c_CNT_MAX);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    // When full, the slot being written is the one being popped this cycle.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : Memory-mapped 8N1 UART transmitter with 4-entry TX FIFO, DIV
//            bit-period register and drain interrupt.
// Revision : 1.0
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'h000F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    logic               r_en;
    logic               r_ie;
    logic [15:0]        r_div;
    logic               r_ovf;
    tx_state_t          r_state;
    logic [15:0]        r_baud;
    logic [7:0]         r_shift;
    logic [2:0]         r_idx;
    logic               r_txd;

    logic               w_rst;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_busy;
    logic [7:0]         w_head;
    logic [c_CNT_W-1:0] w_count;
    logic [c_STAT_CNT_W-1:0] w_count_field;
    logic               w_unused_bits;

    assign w_rst         = ~reset;
    assign w_push        = WE && (Addr[1:0] == c_REG_DATA);
    assign w_pop         = (r_state == S_IDLE) && r_en && !w_empty;
    assign w_busy        = (r_state != S_IDLE);
    assign w_count_field = c_STAT_CNT_W'(w_count);
    assign w_unused_bits = &{1'b0, Addr[29:2], Din[31:16]};

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (w_rst),
        .i_push  (w_push),
        .i_data  (Din[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_en  <= 1'b0;
            r_ie  <= 1'b0;
            r_div <= DIV_RESET;
            r_ovf <= 1'b0;
        end else begin
            if (WE && (Addr[1:0] == c_REG_CTRL)) begin
                r_en <= Din[0];
                r_ie <= Din[1];
            end
            if (WE && (Addr[1:0] == c_REG_DIV)) begin
                r_div <= Din[15:0];
            end
            if (WE && (Addr[1:0] == c_REG_STATUS)) begin
                r_ovf <= 1'b0;
            end else if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Bit counter reloads from live DIV, so a DIV write lands at a bit boundary.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_shift <= '0;
            r_idx   <= '0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_baud  <= r_div;
                        r_txd   <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_baud == '0) begin
                        r_baud  <= r_div;
                        r_idx   <= '0;
                        r_txd   <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                S_DATA: begin
                    if (r_baud == '0) begin
                        r_baud  <= r_div;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_idx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            r_txd <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                S_STOP: begin
                    if (r_baud == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        Dout = '0;
        case (Addr[1:0])
            c_REG_CTRL: Dout[1:0]  = {r_ie, r_en};
            c_REG_DIV:  Dout[15:0] = r_div;
            c_REG_STATUS: begin
                Dout[c_STAT_BUSY]  = w_busy;
                Dout[c_STAT_EMPTY] = w_empty;
                Dout[c_STAT_FULL]  = w_full;
                Dout[c_STAT_OVF]   = r_ovf;
                Dout[c_STAT_CNT_LSB +: c_STAT_CNT_W] = w_count_field;
            end
            default: Dout = '0;
        endcase
    end

    assign IRQ = r_ie && w_empty && (r_state == S_IDLE);
    assign txd = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Directed self-checking bench for uart_tx (DIV=1 frames).
// Revision : 1.0
// ============================================================================
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [29:0] Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;
    logic        txd;

    int n_checks = 0;
    int n_fail   = 0;
    int bp       = 2;

    uart_tx #(
        .FIFO_DEPTH (4),
        .DIV_RESET  (16'h000F)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = {28'd0, a};
        Din  = d;
        WE   = 1'b1;
        step();
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = {28'd0, a};
        #1;
        d = Dout;
    endtask

    // Samples the first cycle of each bit; assumes bit period bp cycles.
    task automatic rx_byte(input string tag, output logic [7:0] b);
        int n;
        n = 0;
        b = 8'h00;
        while (txd !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        check({tag, " start"}, {31'd0, txd}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            repeat (bp) step();
            b[k] = txd;
        end
        repeat (bp) step();
        check({tag, " stop"}, {31'd0, txd}, 32'd1);
    endtask

    logic [31:0] v;
    logic [7:0]  rb;
    logic [9:0]  frame;
    logic [7:0]  exp_q [5];
    logic        saw_low;

    initial begin
        // Reset and reset-value readback
        repeat (3) step();
        reset = 1'b1;
        rd(2'd1, v); check("div reset", v, 32'h0000_000F);
        rd(2'd3, v); check("status reset", v, 32'h0000_0002);
        rd(2'd0, v); check("ctrl reset", v, 32'h0000_0000);
        check("txd reset", {31'd0, txd}, 32'd1);
        check("irq reset", {31'd0, IRQ}, 32'd0);

        // Single frame 0xA5 at DIV=1
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd1);
        wr(2'd2, 32'h0000_00A5);
        rd(2'd3, v); check("status after push", v, 32'h0000_0010);
        check("txd before pop", {31'd0, txd}, 32'd1);
        step();
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 20; i++) begin
            rd(2'd3, v);
            check($sformatf("frame bit %0d", i), {31'd0, txd}, {31'd0, frame[i/2]});
            check($sformatf("busy %0d", i), {31'd0, v[0]}, 32'd1);
            step();
        end
        rd(2'd3, v); check("status after frame", v, 32'h0000_0002);
        check("txd idle after frame", {31'd0, txd}, 32'd1);

        // Overflow with EN=0, clear, then drain
        wr(2'd0, 32'd0);
        wr(2'd2, 32'h11); wr(2'd2, 32'h22); wr(2'd2, 32'h33);
        wr(2'd2, 32'h44); wr(2'd2, 32'h55);
        rd(2'd3, v); check("status full ovf", v, 32'h0000_004C);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, v); check("status ovf cleared", v, 32'h0000_0044);
        rd(2'd0, v); check("ctrl kept", v, 32'h0000_0000);
        rd(2'd1, v); check("div kept", v, 32'h0000_0001);
        wr(2'd0, 32'd1);
        exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            rx_byte("drain", rb);
            check($sformatf("drain byte %0d", i), {24'd0, rb}, {24'd0, exp_q[i]});
        end
        repeat (3) step();
        rd(2'd3, v); check("no fifth byte", v, 32'h0000_0002);
        check("txd idle after drain", {31'd0, txd}, 32'd1);

        // Push into full FIFO in the same cycle as a pop
        wr(2'd0, 32'd0);
        wr(2'd2, 32'h01); wr(2'd2, 32'h02); wr(2'd2, 32'h03); wr(2'd2, 32'h04);
        rd(2'd3, v); check("status full", v, 32'h0000_0044);
        wr(2'd0, 32'd1);
        wr(2'd2, 32'h05);
        rd(2'd3, v); check("push+pop full", v, 32'h0000_0045);
        exp_q[0] = 8'h02; exp_q[1] = 8'h03; exp_q[2] = 8'h04; exp_q[3] = 8'h05;
        rx_byte("pp", rb);
        check("pp byte 0", {24'd0, rb}, 32'h01);
        for (int i = 0; i < 4; i++) begin
            rx_byte("pp", rb);
            check($sformatf("pp byte %0d", i + 1), {24'd0, rb}, {24'd0, exp_q[i]});
        end

        // IRQ on drain
        repeat (4) step();
        wr(2'd0, 32'd2);
        check("irq ie idle empty", {31'd0, IRQ}, 32'd1);
        wr(2'd2, 32'h5A);
        check("irq not empty", {31'd0, IRQ}, 32'd0);
        wr(2'd0, 32'd3);
        check("irq at enable", {31'd0, IRQ}, 32'd0);
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("irq in frame %0d", k), {31'd0, IRQ}, 32'd0);
        end
        step();
        check("irq after frame", {31'd0, IRQ}, 32'd1);
        wr(2'd0, 32'd1);
        check("irq ie cleared", {31'd0, IRQ}, 32'd0);

        // Reset mid data bit
        wr(2'd0, 32'd0);
        wr(2'd2, 32'h00); wr(2'd2, 32'h00); wr(2'd2, 32'h00);
        wr(2'd0, 32'd1);
        repeat (6) step();
        check("txd low in data bit", {31'd0, txd}, 32'd0);
        reset = 1'b0;
        step();
        rd(2'd3, v);
        check("txd after reset", {31'd0, txd}, 32'd1);
        check("status after reset", v, 32'h0000_0002);
        check("irq after reset", {31'd0, IRQ}, 32'd0);
        reset = 1'b1;
        rd(2'd0, v); check("ctrl after reset", v, 32'h0000_0000);
        rd(2'd1, v); check("div after reset", v, 32'h0000_000F);
        wr(2'd0, 32'd1);
        saw_low = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (txd !== 1'b1) saw_low = 1'b1;
            step();
        end
        check("no frame after reset", {31'd0, saw_low}, 32'd0);
        rd(2'd3, v); check("fifo lost", v, 32'h0000_0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
